jtframe_dwnld_pack: RTL and testbench

// Successor to the byte-wise ROM download router. Packs ioctl bytes into 16-bit SDRAM words with full/partial

---
 rtl/jtframe_dwnld_pack.sv | 225 ++++++++++++++++++++++
 tb/tb_jtframe_dwnld_pack.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_dwnld_pack.sv
// Packs the ioctl download byte stream into 16-bit SDRAM words with byte masks and bank routing.
// A small FIFO absorbs ioctl bursts. Bytes in the PROM region go out on a separate byte-wide port.
module jtframe_dwnld_pack #(
  parameter int          AW         = 22,
  parameter logic [24:0] HEADER     = 25'd0,
  parameter logic [24:0] PROM_START = ~25'd0,
  parameter logic [24:0] BA1_START  = ~25'd0,
  parameter logic [24:0] BA2_START  = ~25'd0,
  parameter logic [24:0] BA3_START  = ~25'd0,
  parameter bit          SWAB       = 1'b0,
  parameter int          FIFO_DW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  output logic          header,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic [1:0]    prog_ba,
  output logic          prog_we,
  input  logic          sdram_ack,
  output logic [21:0]   prom_addr,
  output logic [7:0]    prom_data,
  output logic          prom_we,
  output logic          ovf,
  output logic          done
);

  localparam logic [24:0] UNUSED = '1;
  localparam int DEPTH = 1 << FIFO_DW;
  localparam logic [FIFO_DW:0] FULL_CNT = (FIFO_DW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FLUSH} state_t;

  typedef struct packed {
    logic [1:0]    ba;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    mask;
  } word_t;

  state_t state;

  logic [24:0]   part_addr, bank_start;
  logic [AW:0]   eff;
  logic [1:0]    byte_ba;
  logic [AW-1:0] byte_word;
  logic          byte_lane, is_prom;
  logic [21:0]   prom_off;

  if (HEADER != 25'd0) begin : g_header
    assign header = ioctl_addr < HEADER;
  end else begin : g_no_header
    assign header = 1'b0;
  end

  assign part_addr = ioctl_addr - HEADER;
  assign is_prom   = (PROM_START != UNUSED) && (part_addr >= PROM_START);
  assign prom_off  = 22'(part_addr - PROM_START);

  // Later banks override earlier ones, so the highest matching bank wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    byte_ba    = 2'd0;
    bank_start = 25'd0;
    if (BA1_START != UNUSED && part_addr >= BA1_START) begin
      byte_ba    = 2'd1;
      bank_start = BA1_START;
    end
    if (BA2_START != UNUSED && part_addr >= BA2_START) begin
      byte_ba    = 2'd2;
      bank_start = BA2_START;
    end
    if (BA3_START != UNUSED && part_addr >= BA3_START) begin
      byte_ba    = 2'd3;
      bank_start = BA3_START;
    end
  end

  assign eff       = (AW+1)'(part_addr - bank_start);
  assign byte_word = eff[AW:1];
  assign byte_lane = eff[0] ^ SWAB;

  // Pending half-word waiting for its partner lane
  logic          pend_valid, pend_lane;
  logic [AW-1:0] pend_word;
  logic [1:0]    pend_ba;
  logic [7:0]    pend_byte;

  word_t pend_entry, merged_entry, push_entry;
  logic  accept, push, pend_load, pend_clear, prom_hit;

  assign accept = (state == ST_LOAD) && ioctl_wr && !header;

  always_comb begin
    pend_entry.ba   = pend_ba;
    pend_entry.addr = pend_word;
    pend_entry.data = {2{pend_byte}};
    pend_entry.mask = pend_lane ? 2'b10 : 2'b01;

    merged_entry.ba   = pend_ba;
    merged_entry.addr = pend_word;
    merged_entry.data = byte_lane ? {pend_byte, ioctl_data} : {ioctl_data, pend_byte};
    merged_entry.mask = 2'b00;
  end

  always_comb begin
    push       = 1'b0;
    push_entry = pend_entry;
    pend_load  = 1'b0;
    pend_clear = 1'b0;
    prom_hit   = 1'b0;
    if (accept) begin
      if (is_prom) begin
        prom_hit   = 1'b1;
        push       = pend_valid;
        pend_clear = 1'b1;
      end else if (!pend_valid) begin
        pend_load = 1'b1;
      end else if (pend_word == byte_word && pend_ba == byte_ba && pend_lane != byte_lane) begin
        push       = 1'b1;
        push_entry = merged_entry;
        pend_clear = 1'b1;
      end else begin
        push      = 1'b1;
        pend_load = 1'b1;
      end
    end else if (state == ST_FLUSH && pend_valid) begin
      push       = 1'b1;
      pend_clear = 1'b1;
    end
  end

  // Word FIFO towards the SDRAM controller
  word_t              mem [DEPTH];
  word_t              head;
  logic [FIFO_DW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DW:0]   count;
  logic               full, pop, do_push, drop, drained;

  assign full    = count == FULL_CNT;
  assign prog_we = count != '0;
  assign pop     = prog_we && sdram_ack;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign drained = (count == '0) && !pend_valid;
  assign done    = (state == ST_FLUSH) && drained;

  // NOTE: the storage array has no reset; count gates every read, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head      = prog_we ? mem[rd_ptr] : '0;
  assign prog_ba   = head.ba;
  assign prog_addr = head.addr;
  assign prog_data = head.data;
  assign prog_mask = head.mask;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_DW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_DW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (FIFO_DW+1)'(1);
        2'b01:   count <= count - (FIFO_DW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pend_valid <= 1'b0;
      pend_lane  <= 1'b0;
      pend_word  <= '0;
      pend_ba    <= 2'd0;
      pend_byte  <= 8'd0;
      prom_we    <= 1'b0;
      prom_addr  <= 22'd0;
      prom_data  <= 8'd0;
      ovf        <= 1'b0;
    end else begin
      prom_we <= prom_hit;
      if (prom_hit) begin
        prom_addr <= prom_off;
        prom_data <= ioctl_data;
      end

      if (pend_load) begin
        pend_valid <= 1'b1;
        pend_lane  <= byte_lane;
        pend_word  <= byte_word;
        pend_ba    <= byte_ba;
        pend_byte  <= ioctl_data;
      end else if (pend_clear) begin
        pend_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: if (downloading) begin
          state <= ST_LOAD;
          ovf   <= 1'b0;
        end
        ST_LOAD:  if (!downloading) state <= ST_FLUSH;
        ST_FLUSH: if (drained) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      // Dropped data wins over the clear on download start
      if (drop || (ioctl_wr && state != ST_LOAD)) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Bench for jtframe_dwnld_pack: directed scenarios plus random files checked against a
// transaction-level model of the packing, banking and PROM rules.
module tb_jtframe_dwnld_pack;

  localparam int AW      = 22;
  localparam int HDR     = 2;
  localparam int BA1_AT  = 16;
  localparam int BA2_AT  = 32;
  localparam int PROM_AT = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          downloading = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_data = '0;
  logic          ioctl_wr = 1'b0;
  logic          sdram_ack;
  logic          header;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic [1:0]    prog_ba;
  logic          prog_we;
  logic [21:0]   prom_addr;
  logic [7:0]    prom_data;
  logic          prom_we;
  logic          ovf;
  logic          done;

  jtframe_dwnld_pack #(
    .AW(AW), .HEADER(25'(HDR)), .PROM_START(25'(PROM_AT)),
    .BA1_START(25'(BA1_AT)), .BA2_START(25'(BA2_AT)), .BA3_START(~25'd0),
    .SWAB(1'b0), .FIFO_DW(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .header(header), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_ba(prog_ba), .prog_we(prog_we),
    .sdram_ack(sdram_ack), .prom_addr(prom_addr), .prom_data(prom_data),
    .prom_we(prom_we), .ovf(ovf), .done(done)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } wr_t;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
  } pw_t;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } byte_t;

  wr_t   got_q[$], exp_q[$];
  pw_t   got_p[$], exp_p[$];
  byte_t file_q[$];
  int    errors = 0;
  int    checks = 0;
  int    ack_mode = 0;  // 0: always ack, 1: random ack, 2: hold ack low

  // Ack driver and write collector: a head is recorded when it is presented with ack high.
  initial begin : monitor
    logic a;
    wr_t  w;
    pw_t  p;
    sdram_ack = 1'b0;
    forever begin
      @(negedge clk);
      a = (ack_mode == 0) || (ack_mode == 1 && $urandom_range(0, 3) != 0);
      sdram_ack = a;
      if (prog_we && a) begin
        w = {prog_ba, prog_addr, prog_data, prog_mask};
        got_q.push_back(w);
      end
      if (prom_we) begin
        p = {prom_addr, prom_data};
        got_p.push_back(p);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk(input int b, input int w, input logic [15:0] d, input logic [1:0] m);
    wr_t r;
    r.ba = 2'(b); r.addr = 22'(w); r.data = d; r.mask = m;
    return r;
  endfunction

  function automatic wr_t wr_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  function automatic pw_t pw_at(input int i);
    if (i < got_p.size()) return got_p[i];
    return 'x;
  endfunction

  // Reference: walk the file in order, pairing bytes of one 16-bit word (even offset -> [15:8]).
  function automatic void model();
    bit         pv;
    int         pb, pw, pl;
    logic [7:0] pd;
    pv = 0; pb = 0; pw = 0; pl = 0; pd = '0;
    exp_q.delete();
    exp_p.delete();
    foreach (file_q[i]) begin
      int         part, b, base, off, lane, word;
      logic [7:0] d;
      pw_t        p;
      d = file_q[i].data;
      if (file_q[i].addr < HDR) continue;
      part = file_q[i].addr - HDR;
      if (part >= PROM_AT) begin
        if (pv) exp_q.push_back(mk(pb, pw, {pd, pd}, pl == 1 ? 2'b10 : 2'b01));
        pv = 0;
        p = {22'(part - PROM_AT), d};
        exp_p.push_back(p);
        continue;
      end
      b    = part >= BA2_AT ? 2 : (part >= BA1_AT ? 1 : 0);
      base = b == 2 ? BA2_AT : (b == 1 ? BA1_AT : 0);
      off  = part - base;
      word = off / 2;
      lane = off % 2;
      if (pv && pw == word && pb == b && pl != lane) begin
        exp_q.push_back(mk(pb, pw, lane == 1 ? {pd, d} : {d, pd}, 2'b00));
        pv = 0;
      end else begin
        if (pv) exp_q.push_back(mk(pb, pw, {pd, pd}, pl == 1 ? 2'b10 : 2'b01));
        pv = 1; pb = b; pw = word; pl = lane; pd = d;
      end
    end
    if (pv) exp_q.push_back(mk(pb, pw, {pd, pd}, pl == 1 ? 2'b10 : 2'b01));
  endfunction

  task automatic add_byte(input int addr, input logic [7:0] d);
    byte_t e;
    e.addr = addr;
    e.data = d;
    file_q.push_back(e);
  endtask

  task automatic send_byte(input int addr, input logic [7:0] d, input int gap, input bit chk_hdr);
    @(negedge clk);
    ioctl_addr = 25'(addr);
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    if (chk_hdr) begin
      #1;
      check($sformatf("header_at_%0d", addr), header, addr < HDR);
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_file(input int gap_lo, input int gap_hi);
    foreach (file_q[i]) send_byte(file_q[i].addr, file_q[i].data, $urandom_range(gap_lo, gap_hi), 1'b0);
  endtask

  task automatic start_dl();
    @(negedge clk);
    got_q.delete();
    got_p.delete();
    downloading = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done"}, seen, 1'b1);
    @(negedge clk);
    check({tag, "_done_width"}, done, 1'b0);
  endtask

  task automatic end_dl(input string tag);
    @(negedge clk);
    downloading = 1'b0;
    wait_done(tag);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_nwr"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) check($sformatf("%s_wr%0d", tag, i), wr_at(i), exp_q[i]);
    check({tag, "_nprom"}, got_p.size(), exp_p.size());
    foreach (exp_p[i]) check($sformatf("%s_prom%0d", tag, i), pw_at(i), exp_p[i]);
  endtask

  task automatic random_file();
    int len, nxt, a;
    file_q.delete();
    len = $urandom_range(20, 64);
    nxt = 0;
    for (int i = 0; i < len; i++) begin
      a = ($urandom_range(0, 5) == 0) ? $urandom_range(0, HDR + PROM_AT + 15) : nxt;
      add_byte(a, 8'($urandom));
      nxt = a + 1;
    end
  endtask

  initial begin : main
    wr_t w;

    // Reset state
    ack_mode = 2;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {prog_we, prom_we, ovf, done}, 4'b0000);
    check("rst_prog", {prog_ba, prog_addr, prog_data, prog_mask}, 0);
    check("rst_prom", {prom_addr, prom_data}, 0);
    check("rst_header", header, 1'b1);
    rst_n = 1'b1;
    ack_mode = 0;

    // Header skip and two full words
    start_dl();
    send_byte(0, 8'hE0, 1, 1'b1);
    send_byte(1, 8'hE1, 1, 1'b1);
    send_byte(2, 8'h11, 1, 1'b1);
    send_byte(3, 8'h22, 1, 1'b0);
    send_byte(4, 8'h33, 1, 1'b0);
    send_byte(5, 8'h44, 1, 1'b0);
    end_dl("four");
    check("four_n", got_q.size(), 2);
    check("four_w0", wr_at(0), {2'd0, 22'd0, 16'h1122, 2'b00});
    check("four_w1", wr_at(1), {2'd0, 22'd1, 16'h3344, 2'b00});
    check("four_ovf", ovf, 1'b0);

    // Odd length: trailing half-word flushed with the upper lane only
    start_dl();
    send_byte(2, 8'h11, 0, 1'b0);
    send_byte(3, 8'h22, 0, 1'b0);
    send_byte(4, 8'h33, 0, 1'b0);
    end_dl("odd");
    check("odd_n", got_q.size(), 2);
    check("odd_w1", wr_at(1), {2'd0, 22'd1, 16'h3333, 2'b01});

    // Bank 0 -> bank 1 boundary
    file_q.delete();
    for (int p = 14; p < 20; p++) add_byte(HDR + p, 8'($urandom));
    model();
    start_dl();
    send_file(0, 2);
    end_dl("bank");
    compare_all("bank");
    w = wr_at(1);
    check("bank_ba1_w0", {w.ba, w.addr}, {2'd1, 22'd0});

    // Single PROM byte
    start_dl();
    send_byte(HDR + PROM_AT + 1, 8'hAA, 2, 1'b0);
    check("prom_n", got_p.size(), 1);
    check("prom_byte", pw_at(0), {22'd1, 8'hAA});
    check("prom_noprog", got_q.size(), 0);
    end_dl("prom");

    // FIFO overflow while the SDRAM stalls
    file_q.delete();
    for (int p = 0; p < 12; p++) add_byte(HDR + p, 8'($urandom));
    model();
    ack_mode = 2;
    start_dl();
    send_file(0, 0);
    repeat (2) @(negedge clk);
    check("ovf_set", ovf, 1'b1);
    check("ovf_we_held", prog_we, 1'b1);
    downloading = 1'b0;
    repeat (5) @(negedge clk);
    check("ovf_no_done", done, 1'b0);
    ack_mode = 0;
    wait_done("ovf");
    check("ovf_nwr", got_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("ovf_wr%0d", i), wr_at(i), exp_q[i]);
    check("ovf_sticky", ovf, 1'b1);
    start_dl();
    check("ovf_clear", ovf, 1'b0);
    end_dl("empty");

    // Strobe outside a download
    send_byte(HDR + 3, 8'h5A, 1, 1'b0);
    check("idle_wr_ovf", ovf, 1'b1);
    check("idle_wr_nothing", got_q.size() + got_p.size(), 0);

    // Random files with random SDRAM back-pressure
    ack_mode = 1;
    for (int t = 0; t < 6; t++) begin
      random_file();
      model();
      start_dl();
      if (t == 0) check("rand_ovf_clear", ovf, 1'b0);
      send_file(2, 3);
      end_dl($sformatf("rand%0d", t));
      compare_all($sformatf("rand%0d", t));
      check($sformatf("rand%0d_ovf", t), ovf, 1'b0);
    end

    // Asynchronous reset in the middle of a burst
    ack_mode = 2;
    start_dl();
    for (int p = 0; p < 12; p++) send_byte(HDR + p, 8'($urandom), 0, 1'b0);
    @(negedge clk);
    ioctl_addr = 25'(HDR + PROM_AT + 2);
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    check("mid_pre", {prog_we, prom_we, ovf}, 3'b111);
    #2 rst_n = 1'b0;
    #1 check("mid_rst", {prog_we, prom_we, ovf, done}, 4'b0000);
    @(negedge clk);
    downloading = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_empty", {prog_we, done, ovf}, 3'b000);

    ack_mode = 1;
    random_file();
    model();
    start_dl();
    send_file(2, 3);
    end_dl("post");
    compare_all("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
